// File: rtl/alu_cmd_sequencer_if.sv
// Byte-stream, ALU and TX signal bundle for alu_cmd_sequencer.
// The slave modport is the sequencer's view; the master modport is its environment.
interface alu_cmd_sequencer_if;
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic signed [15:0] A;
  logic signed [15:0] B;
  logic [3:0]         ALU_FUN;
  logic               alu_en;
  logic [15:0]        Arith_out;
  logic [15:0]        Logic_out;
  logic [15:0]        CMP_out;
  logic [15:0]        SHIFT_out;
  logic               Arith_flag;
  logic               Logic_flag;
  logic               CMP_flag;
  logic               SHIFT_flag;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic               busy;
  logic               frame_err;
  logic               overrun;

  modport master (
    output rx_data, rx_valid, tx_ready,
    output Arith_out, Logic_out, CMP_out, SHIFT_out,
    output Arith_flag, Logic_flag, CMP_flag, SHIFT_flag,
    input  A, B, ALU_FUN, alu_en, tx_data, tx_valid, busy, frame_err, overrun
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    input  Arith_out, Logic_out, CMP_out, SHIFT_out,
    input  Arith_flag, Logic_flag, CMP_flag, SHIFT_flag,
    output A, B, ALU_FUN, alu_en, tx_data, tx_valid, busy, frame_err, overrun
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Parses RX command frames into ALU operands/function, launches one ALU operation,
// then returns the flagged 16-bit result as two TX bytes, LSB first.
module alu_cmd_sequencer #(
  parameter int unsigned OPER_W     = 16,
  parameter int unsigned ALU_LAT    = 1,
  parameter logic [7:0]  CMD_OPER   = 8'hCC,
  parameter logic [7:0]  CMD_NOOPER = 8'hDD
) (
  input logic                clk,
  input logic                RST,
  alu_cmd_sequencer_if.slave bus
);

  localparam int unsigned CntW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [3:0] {
    StIdle, StGetA0, StGetA1, StGetB0, StGetB1, StGetFun, StExec, StWait, StSendLo, StSendHi
  } state_e;

  state_e              r_state, w_state_d;
  logic [OPER_W-1:0]   r_a_stg, w_a_stg_d;
  logic [OPER_W-1:0]   r_b_stg, w_b_stg_d;
  logic [OPER_W-1:0]   r_a, w_a_d;
  logic [OPER_W-1:0]   r_b, w_b_d;
  logic [3:0]          r_fun, w_fun_d;
  logic [OPER_W-1:0]   r_result, w_result_d;
  logic [CntW-1:0]     r_cnt, w_cnt_d;
  logic                r_ferr, w_ferr_d;
  logic                r_ovr, w_ovr_d;
  logic                w_rx;

  assign w_rx = bus.rx_valid;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state  <= StIdle;
      r_a_stg  <= '0;
      r_b_stg  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_fun    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_ferr   <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_a_stg  <= w_a_stg_d;
      r_b_stg  <= w_b_stg_d;
      r_a      <= w_a_d;
      r_b      <= w_b_d;
      r_fun    <= w_fun_d;
      r_result <= w_result_d;
      r_cnt    <= w_cnt_d;
      r_ferr   <= w_ferr_d;
      r_ovr    <= w_ovr_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_a_stg_d  = r_a_stg;
    w_b_stg_d  = r_b_stg;
    w_a_d      = r_a;
    w_b_d      = r_b;
    w_fun_d    = r_fun;
    w_result_d = r_result;
    w_cnt_d    = r_cnt;
    w_ferr_d   = 1'b0;
    // Bytes arriving after launch are never buffered.
    w_ovr_d    = w_rx && (r_state == StExec || r_state == StWait ||
                          r_state == StSendLo || r_state == StSendHi);
    case (r_state)
      StIdle: begin
        if (w_rx) begin
          if (bus.rx_data == CMD_OPER) begin
            w_state_d = StGetA0;
          end else if (bus.rx_data == CMD_NOOPER) begin
            w_state_d = StGetFun;
          end else begin
            w_ferr_d = 1'b1;
          end
        end
      end
      StGetA0: if (w_rx) begin
        w_a_stg_d[7:0] = bus.rx_data;
        w_state_d      = StGetA1;
      end
      StGetA1: if (w_rx) begin
        w_a_stg_d[15:8] = bus.rx_data;
        w_state_d       = StGetB0;
      end
      StGetB0: if (w_rx) begin
        w_b_stg_d[7:0] = bus.rx_data;
        w_state_d      = StGetB1;
      end
      StGetB1: if (w_rx) begin
        w_b_stg_d[15:8] = bus.rx_data;
        w_state_d       = StGetFun;
      end
      StGetFun: if (w_rx) begin
        // Staging equals the live operands unless a full frame just refilled it.
        w_fun_d   = bus.rx_data[3:0];
        w_a_d     = r_a_stg;
        w_b_d     = r_b_stg;
        w_state_d = StExec;
      end
      StExec: begin
        w_cnt_d   = '0;
        w_state_d = StWait;
      end
      StWait: begin
        w_cnt_d = r_cnt + CntW'(1);
        if (r_cnt == CntW'(ALU_LAT - 1)) begin
          w_state_d = StSendLo;
          if (bus.Arith_flag) begin
            w_result_d = bus.Arith_out;
          end else if (bus.Logic_flag) begin
            w_result_d = bus.Logic_out;
          end else if (bus.CMP_flag) begin
            w_result_d = bus.CMP_out;
          end else if (bus.SHIFT_flag) begin
            w_result_d = bus.SHIFT_out;
          end else begin
            w_result_d = '0;
            w_ferr_d   = 1'b1;
          end
        end
      end
      StSendLo: if (bus.tx_ready) w_state_d = StSendHi;
      StSendHi: if (bus.tx_ready) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  assign bus.A         = r_a;
  assign bus.B         = r_b;
  assign bus.ALU_FUN   = r_fun;
  assign bus.alu_en    = (r_state == StExec);
  assign bus.busy      = (r_state != StIdle);
  assign bus.tx_valid  = (r_state == StSendLo) || (r_state == StSendHi);
  assign bus.tx_data   = (r_state == StSendHi) ? r_result[15:8] : r_result[7:0];
  assign bus.frame_err = r_ferr;
  assign bus.overrun   = r_ovr;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a frame-level model, a stub ALU and
// a per-cycle compare process.
module tb_alu_cmd_sequencer;

  logic clk = 1'b0;
  logic RST = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if bus();

  alu_cmd_sequencer #(.ALU_LAT(1)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q[$];
  logic [35:0] launch_q[$];
  int          tx_log[$];
  int          ferr_cnt = 0, ovr_cnt = 0, exp_ferr = 0, exp_ovr = 0;
  logic [15:0] m_a = '0, m_b = '0;
  logic        stub_forced = 1'b0;
  logic [3:0]  stub_mask = '0;

  localparam logic [15:0] KArith = 16'h1A1A, KLogic = 16'h2B2B;
  localparam logic [15:0] KCmp = 16'h3C3C, KShift = 16'h4D4D;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference ALU: arith 0-3, logic 4-7, compare 8-B, shift C-F.
  function automatic logic [15:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] fun);
    logic signed [15:0] sa, sb;
    sa = a;
    sb = b;
    case (fun)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a * b;
      4'h3: return (b == 0) ? 16'h0 : 16'(sa / sb);
      4'h4: return a & b;
      4'h5: return a | b;
      4'h6: return ~(a & b);
      4'h7: return ~(a | b);
      4'h8: return 16'h0;
      4'h9: return (a == b) ? 16'd1 : 16'd0;
      4'hA: return (sa > sb) ? 16'd2 : 16'd0;
      4'hB: return (sa < sb) ? 16'd3 : 16'd0;
      4'hC: return a >> 1;
      4'hD: return a << 1;
      4'hE: return b >> 1;
      default: return b << 1;
    endcase
  endfunction

  function automatic logic [15:0] exp_result(input logic [15:0] a, input logic [15:0] b,
                                             input logic [3:0] fun);
    if (!stub_forced) return alu_ref(a, b, fun);
    if (stub_mask[3]) return KArith;
    if (stub_mask[2]) return KLogic;
    if (stub_mask[1]) return KCmp;
    if (stub_mask[0]) return KShift;
    return 16'h0;
  endfunction

  // Stub ALU: one-cycle latency, the flag of the addressed group is valid for one cycle.
  always @(posedge clk or negedge RST) begin
    if (!RST) begin
      {bus.Arith_flag, bus.Logic_flag, bus.CMP_flag, bus.SHIFT_flag} <= 4'b0;
      {bus.Arith_out, bus.Logic_out, bus.CMP_out, bus.SHIFT_out} <= '0;
    end else if (bus.alu_en) begin
      if (stub_forced) begin
        {bus.Arith_flag, bus.Logic_flag, bus.CMP_flag, bus.SHIFT_flag} <= stub_mask;
        {bus.Arith_out, bus.Logic_out, bus.CMP_out, bus.SHIFT_out} <= {KArith, KLogic, KCmp, KShift};
      end else begin
        logic [15:0] r;
        r = alu_ref(bus.A, bus.B, bus.ALU_FUN);
        {bus.Arith_out, bus.Logic_out, bus.CMP_out, bus.SHIFT_out} <= '0;
        {bus.Arith_flag, bus.Logic_flag, bus.CMP_flag, bus.SHIFT_flag} <= 4'b1000 >> bus.ALU_FUN[3:2];
        case (bus.ALU_FUN[3:2])
          2'd0: bus.Arith_out <= r;
          2'd1: bus.Logic_out <= r;
          2'd2: bus.CMP_out   <= r;
          default: bus.SHIFT_out <= r;
        endcase
      end
    end else begin
      {bus.Arith_flag, bus.Logic_flag, bus.CMP_flag, bus.SHIFT_flag} <= 4'b0;
    end
  end

  // Compare process, sampled mid-cycle.
  logic        prev_hold = 1'b0;
  logic [7:0]  prev_data = '0;
  logic [35:0] prev_op = '0;
  always @(negedge clk) begin
    if (RST) begin
      if (bus.tx_valid && bus.tx_ready) begin
        tx_log.push_back(int'(bus.tx_data));
        if (exp_q.size() == 0) check("tx_unexpected", 1, 0);
        else check("tx_byte", bus.tx_data, exp_q.pop_front());
      end
      if (prev_hold) begin
        check("hold_valid", bus.tx_valid, 1);
        check("hold_data", bus.tx_data, prev_data);
      end
      if (bus.alu_en) begin
        if (launch_q.size() == 0) check("launch_unexpected", 1, 0);
        else check("launch_ops", {bus.A, bus.B, bus.ALU_FUN}, launch_q.pop_front());
      end
      if ({bus.A, bus.B, bus.ALU_FUN} != prev_op) check("ops_changed_only_at_launch", bus.alu_en, 1);
      if (bus.frame_err) ferr_cnt++;
      if (bus.overrun) ovr_cnt++;
    end
    prev_hold = RST && bus.tx_valid && !bus.tx_ready;
    prev_data = bus.tx_data;
    prev_op   = {bus.A, bus.B, bus.ALU_FUN};
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    cyc();
    bus.rx_valid = 1'b0;
  endtask

  task automatic push_expect(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun);
    logic [15:0] r;
    r = exp_result(a, b, fun);
    launch_q.push_back({a, b, fun});
    exp_q.push_back(r[7:0]);
    exp_q.push_back(r[15:8]);
    if (stub_forced && stub_mask == 4'b0) exp_ferr++;
  endtask

  task automatic frame_full(input logic [15:0] a, input logic [15:0] b, input logic [7:0] fb);
    m_a = a;
    m_b = b;
    push_expect(a, b, fb[3:0]);
    send_byte(8'hCC);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(b[7:0]);
    send_byte(b[15:8]);
    send_byte(fb);
  endtask

  task automatic frame_short(input logic [7:0] fb);
    push_expect(m_a, m_b, fb[3:0]);
    send_byte(8'hDD);
    send_byte(fb);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy && n < 200) begin
      cyc();
      n++;
    end
    check(name, bus.busy, 0);
  endtask

  task automatic log_check(input string name, input int lo, input int hi);
    int g0 = -1, g1 = -1;
    if (tx_log.size() > 0) g0 = tx_log.pop_front();
    if (tx_log.size() > 0) g1 = tx_log.pop_front();
    check({name, "_lo"}, g0, lo);
    check({name, "_hi"}, g1, hi);
  endtask

  initial begin
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    repeat (3) cyc();
    check("rst_outputs", {bus.A, bus.B, bus.ALU_FUN, bus.tx_data},
          {16'h0, 16'h0, 4'h0, 8'h0});
    check("rst_ctrl", {bus.tx_valid, bus.busy, bus.frame_err, bus.overrun, bus.alu_en}, 0);
    RST = 1'b1;
    cyc();

    frame_full(16'd5, 16'd3, 8'h00);
    check("t1_a", bus.A, 16'd5);
    check("t1_b", bus.B, 16'd3);
    wait_idle("t1_idle");
    log_check("t1_add", 8'h08, 8'h00);

    frame_short(8'h02);
    wait_idle("t2_idle_mul");
    log_check("t2_mul", 8'h0F, 8'h00);
    check("t2_ab_kept", {bus.A, bus.B}, {16'd5, 16'd3});
    frame_short(8'h0A);
    wait_idle("t2_idle_gt");
    log_check("t2_gt", 8'h02, 8'h00);
    frame_short(8'hF4);
    wait_idle("t2_idle_and");
    log_check("t2_fun_hi_ignored", 8'h01, 8'h00);

    bus.tx_ready = 1'b0;
    frame_full(16'hFFFF, 16'h1001, 8'h01);
    begin
      int n = 0;
      while (!bus.tx_valid && n < 50) begin
        cyc();
        n++;
      end
      check("t3_tx_valid_seen", bus.tx_valid, 1);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        exp_ovr++;
        send_byte(8'h77);
      end else begin
        cyc();
      end
      check("t3_held_byte", {bus.tx_valid, bus.tx_data}, {1'b1, 8'hFE});
    end
    check("t4_overrun", ovr_cnt, exp_ovr);
    bus.tx_ready = 1'b1;
    wait_idle("t3_idle");
    log_check("t3_sub", 8'hFE, 8'hEF);

    exp_ferr++;
    send_byte(8'h55);
    for (int i = 0; i < 3; i++) begin
      check("t4_busy_stays_0", bus.busy, 0);
      cyc();
    end
    check("t4_frame_err", ferr_cnt, exp_ferr);

    send_byte(8'hCC);
    send_byte(8'h01);
    send_byte(8'h00);
    RST = 1'b0;
    cyc();
    cyc();
    RST = 1'b1;
    m_a = '0;
    m_b = '0;
    cyc();
    check("t5_busy_after_rst", bus.busy, 0);
    frame_short(8'h00);
    check("t5_ab_zero", {bus.A, bus.B}, 32'h0);
    wait_idle("t5_idle");
    log_check("t5_zero", 8'h00, 8'h00);

    stub_forced = 1'b1;
    stub_mask   = 4'b0000;
    frame_short(8'h00);
    wait_idle("t6_idle");
    log_check("t6_no_flag", 8'h00, 8'h00);
    check("t6_frame_err", ferr_cnt, exp_ferr);
    stub_mask = 4'b0111;
    frame_short(8'h00);
    wait_idle("t6_idle_logic");
    log_check("t6_prio_logic", 8'h2B, 8'h2B);
    stub_mask = 4'b1111;
    frame_short(8'h00);
    wait_idle("t6_idle_arith");
    log_check("t6_prio_arith", 8'h1A, 8'h1A);
    stub_mask = 4'b0011;
    frame_short(8'h00);
    wait_idle("t6_idle_cmp");
    log_check("t6_prio_cmp", 8'h3C, 8'h3C);
    stub_forced = 1'b0;

    repeat (3) cyc();
    check("end_tx_queue_empty", exp_q.size(), 0);
    check("end_launch_queue_empty", launch_q.size(), 0);
    check("end_frame_err_count", ferr_cnt, exp_ferr);
    check("end_overrun_count", ovr_cnt, exp_ovr);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
